// File: rtl/transceiver_sequencer.sv
// transceiver_sequencer
//   Per-byte sequencer between UART RX and the Hamming codec / UART TX /
//   BPSK modulator. Received bytes are buffered in a small circular FIFO and
//   presented to the encoder one at a time. After the codec pipeline settles,
//   a UART TX frame and a modulator burst are launched, and the next byte is
//   held off until both have finished.
//
// Parameters
//   FIFO_DEPTH  byte buffer depth (power of two, >= 2)
//   PIPE_LAT    cycles from enc_data change to a valid decoder output (>= 1)
//   MOD_CYCLES  mod_en high-time per codeword
//
// Ports
//   clk         system clock
//   rst         asynchronous active-low reset
//   rx_dv       one-cycle strobe: rx_byte valid
//   rx_byte     received byte
//   tx_active   UART TX busy
//   tx_done     UART TX one-cycle end-of-frame strobe
//   enc_data    byte presented to the encoder (registered, held until next pop)
//   tx_dv       one-cycle start strobe to UART TX
//   mod_en      modulator enable (registered)
//   busy        high whenever the sequencer is not idle
//   overflow    sticky: a byte was dropped because the FIFO was full
//   fifo_count  current FIFO occupancy
module transceiver_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PIPE_LAT   = 2,
  parameter int unsigned MOD_CYCLES = 3072
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_dv,
  input  logic [7:0]                    rx_byte,
  input  logic                          tx_active,
  input  logic                          tx_done,
  output logic [7:0]                    enc_data,
  output logic                          tx_dv,
  output logic                          mod_en,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned LW = $clog2(PIPE_LAT + 1);
  localparam int unsigned MW = $clog2(MOD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PIPE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [LW-1:0]  r_lat_cnt;
  logic [MW-1:0]  r_mod_cnt;
  logic           r_mod_en;
  logic           r_tx_seen;
  logic           r_overflow;
  logic [7:0]     r_enc;

  logic           w_full;
  logic           w_pop;
  logic           w_push;
  logic           w_tx_dv;

  assign w_full = (r_count == CW'(FIFO_DEPTH));
  // Pop only on the IDLE->PIPE transition.
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && !tx_active;
  // A simultaneous pop frees the head slot, so a full FIFO still accepts.
  assign w_push = rx_dv && (!w_full || w_pop);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_next  = r_state;
    w_tx_dv = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pop) w_next = S_PIPE;
      end
      S_PIPE: begin
        if (r_lat_cnt == '0) w_next = S_SEND;
      end
      S_SEND: begin
        w_tx_dv = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        if (!r_mod_en && (r_tx_seen || tx_done)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_byte;
  end

  // FIFO pointers, occupancy, overflow flag and encoder byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_enc      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        // Reads the pre-edge slot contents, so a same-cycle push into this
        // slot (full FIFO) does not disturb the byte being popped.
        r_enc    <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (rx_dv && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Pipeline latency counter, modulator burst and TX completion tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat_cnt <= '0;
      r_mod_cnt <= '0;
      r_mod_en  <= 1'b0;
      r_tx_seen <= 1'b0;
    end else begin
      if (w_pop) begin
        r_lat_cnt <= LW'(PIPE_LAT - 1);
      end else if ((r_state == S_PIPE) && (r_lat_cnt != '0)) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end

      if (r_state == S_SEND) begin
        r_mod_en  <= 1'b1;
        r_mod_cnt <= MW'(MOD_CYCLES - 1);
        // A tx_done landing in SEND still counts as frame completion.
        r_tx_seen <= tx_done;
      end else if (r_state == S_WAIT) begin
        if (r_mod_en) begin
          if (r_mod_cnt == '0) r_mod_en  <= 1'b0;
          else                 r_mod_cnt <= r_mod_cnt - 1'b1;
        end
        if (tx_done) r_tx_seen <= 1'b1;
      end
    end
  end

  assign enc_data   = r_enc;
  assign tx_dv      = w_tx_dv;
  assign mod_en     = r_mod_en;
  assign busy       = (r_state != S_IDLE);
  assign overflow   = r_overflow;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_transceiver_sequencer.sv
// Directed testbench for transceiver_sequencer (FIFO_DEPTH=4, PIPE_LAT=2,
// MOD_CYCLES=16). A small UART TX model raises tx_active one cycle after
// tx_dv and pulses tx_done done_delay cycles after tx_dv.
module tb_transceiver_sequencer;

  localparam int unsigned LIMIT = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_active = 1'b0;
  logic       tx_done   = 1'b0;
  logic [7:0] enc_data;
  logic       tx_dv;
  logic       mod_en;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_count;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned done_delay = 20;

  transceiver_sequencer #(
    .FIFO_DEPTH (4),
    .PIPE_LAT   (2),
    .MOD_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_dv      (rx_dv),
    .rx_byte    (rx_byte),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .enc_data   (enc_data),
    .tx_dv      (tx_dv),
    .mod_en     (mod_en),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // UART TX model
  int unsigned tcnt = 0;
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (tx_dv) begin
      tx_active <= 1'b1;
      tcnt      <= 1;
    end else if (tx_active) begin
      tcnt <= tcnt + 1;
      if (tcnt == done_delay - 1) tx_done   <= 1'b1;
      if (tcnt == done_delay)     tx_active <= 1'b0;
    end
  end

  // Monitor: launched bytes, burst lengths and protocol invariants
  logic [7:0]  sent_q[$];
  logic [7:0]  burst_byte = 8'h00;
  logic        txdv_prev  = 1'b0;
  logic        mod_prev   = 1'b0;
  int unsigned run_len  = 0;
  int unsigned last_len = 0;
  int unsigned pulses   = 0;
  int unsigned stab_err = 0;
  int unsigned dbl_err  = 0;
  int unsigned rise_err = 0;
  always @(negedge clk) begin
    if (tx_dv === 1'b1) begin
      sent_q.push_back(enc_data);
      burst_byte = enc_data;
    end
    if (tx_dv === 1'b1 && txdv_prev) dbl_err++;
    if (mod_en === 1'b1 && !mod_prev && !txdv_prev) rise_err++;
    if (mod_en === 1'b1 && enc_data !== burst_byte) stab_err++;
    if (mod_en === 1'b1) begin
      run_len++;
    end else if (run_len != 0) begin
      last_len = run_len;
      pulses++;
      run_len = 0;
    end
    txdv_prev = (tx_dv === 1'b1);
    mod_prev  = (mod_en === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bytes(input logic [7:0] b [$]);
    foreach (b[i]) begin
      @(negedge clk);
      rx_dv   = 1'b1;
      rx_byte = b[i];
    end
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic wait_tx_dv(output int unsigned n);
    n = 0;
    while (tx_dv !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < LIMIT);
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n;
    n = 0;
    while (!(busy === 1'b0 && fifo_count === 3'd0) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < LIMIT), 32'd1);
  endtask

  initial begin
    int unsigned n;
    int unsigned base;
    int unsigned p0;
    logic [7:0] seq [$];

    rst     = 1'b0;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_enc",   32'(enc_data),   32'h00);
    check("rst_txdv",  32'(tx_dv),      32'd0);
    check("rst_moden", 32'(mod_en),     32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_ovf",   32'(overflow),   32'd0);
    check("rst_cnt",   32'(fifo_count), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte A5
    base = sent_q.size();
    p0   = pulses;
    seq  = '{8'hA5};
    send_bytes(seq);                               // now just after E
    check("single_cnt_E",   32'(fifo_count), 32'd1);
    check("single_busy_E",  32'(busy),       32'd0);
    @(negedge clk);                                // after E+1
    check("single_enc",     32'(enc_data),   32'hA5);
    check("single_cnt_pop", 32'(fifo_count), 32'd0);
    check("single_busy",    32'(busy),       32'd1);
    wait_tx_dv(n);
    check("single_txdv_lat", n, 32'd2);            // tx_dv sampled at E+4
    wait_idle(n);
    check("single_idle_lat", n, 32'd21);           // tx_done 20 cycles after tx_dv
    check("single_modlen",  last_len,        32'd16);
    check("single_pulses",  pulses - p0,     32'd1);
    check("single_sent",    32'(sent_q.size() - base), 32'd1);
    check("single_byte",    32'(sent_q[base]), 32'hA5);
    check("single_cnt_end", 32'(fifo_count), 32'd0);
    check("single_moden0",  32'(mod_en),     32'd0);

    // Three consecutive bytes
    base = sent_q.size();
    seq  = '{8'h11, 8'h22, 8'h33};
    send_bytes(seq);
    wait_drain("three_drain");
    check("three_sent", 32'(sent_q.size() - base), 32'd3);
    check("three_b0",   32'(sent_q[base]),     32'h11);
    check("three_b1",   32'(sent_q[base + 1]), 32'h22);
    check("three_b2",   32'(sent_q[base + 2]), 32'h33);
    check("three_ovf",  32'(overflow),         32'd0);

    // Push coincident with pop while full
    base = sent_q.size();
    seq  = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_bytes(seq);
    check("full_cnt",     32'(fifo_count), 32'd4);
    check("full_ovf",     32'(overflow),   32'd0);
    wait_idle(n);
    check("full_idle_ok", 32'(n < LIMIT),  32'd1);
    check("full_pre_cnt", 32'(fifo_count), 32'd4);
    rx_dv   = 1'b1;                                // coincides with the pop edge
    rx_byte = 8'hC5;
    @(negedge clk);
    rx_dv = 1'b0;
    check("coinc_cnt",  32'(fifo_count), 32'd4);
    check("coinc_ovf",  32'(overflow),   32'd0);
    check("coinc_busy", 32'(busy),       32'd1);
    wait_drain("coinc_drain");
    check("coinc_sent", 32'(sent_q.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("coinc_byte", 32'(sent_q[base + i]), 32'hC0 + 32'(i));
    end

    // Six bytes back-to-back: 06 is dropped
    base = sent_q.size();
    seq  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_bytes(seq);
    check("ovf_cnt",  32'(fifo_count), 32'd4);
    check("ovf_flag", 32'(overflow),   32'd1);
    wait_drain("ovf_drain");
    check("ovf_sent", 32'(sent_q.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("ovf_byte", 32'(sent_q[base + i]), 32'h01 + 32'(i));
    end
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Late tx_done (60 cycles)
    done_delay = 60;
    base = sent_q.size();
    p0   = pulses;
    seq  = '{8'h77, 8'h78};
    send_bytes(seq);
    wait_tx_dv(n);
    check("late_txdv_ok", 32'(n < LIMIT), 32'd1);
    check("late_enc0",    32'(enc_data),  32'h77);
    wait_idle(n);
    check("late_idle_lat", n,               32'd61);
    check("late_modlen",   last_len,        32'd16);
    check("late_pulses",   pulses - p0,     32'd1);
    check("late_held",     32'(sent_q.size() - base), 32'd1);
    check("late_cnt",      32'(fifo_count), 32'd1);
    wait_tx_dv(n);
    done_delay = 20;
    check("late_next_lat", n,             32'd3);
    check("late_enc1",     32'(enc_data), 32'h78);
    wait_drain("late_drain");
    check("late_sent", 32'(sent_q.size() - base), 32'd2);

    // Reset asserted mid-burst with two bytes buffered
    seq = '{8'hD1, 8'hD2, 8'hD3};
    send_bytes(seq);
    wait_tx_dv(n);
    @(negedge clk);
    check("mid_pre_moden", 32'(mod_en),     32'd1);
    check("mid_pre_cnt",   32'(fifo_count), 32'd2);
    base = sent_q.size();
    rst = 1'b0;
    #1;
    check("mid_moden", 32'(mod_en),     32'd0);
    check("mid_busy",  32'(busy),       32'd0);
    check("mid_cnt",   32'(fifo_count), 32'd0);
    check("mid_ovf",   32'(overflow),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_sent", 32'(sent_q.size() - base), 32'd0);
    check("post_rst_busy", 32'(busy),       32'd0);
    check("post_rst_cnt",  32'(fifo_count), 32'd0);

    // Protocol invariants over the whole run
    check("inv_txdv_double", dbl_err,  32'd0);
    check("inv_mod_rise",    rise_err, 32'd0);
    check("inv_enc_stable",  stab_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
